fifoin_upsize: RTL
==================

// Module: fifoin_upsize
// PURPOSE
//  Single-clock 32->256 bit packer: write-side counterpart of the 256->32 read-out FIFO path.
//  Collects RATIO narrow words from a pixel/stream source into one wide word for the DDR write FIFO.
//  2-entry output queue absorbs one cycle of downstream stall without dropping input rate.
// PARAMETERS
//  IN_WIDTH   32  narrow input word width
//  RATIO      8   narrow words per wide word (power of 2, 2..32)
//  (local) OUT_WIDTH = IN_WIDTH*RATIO (256); LANE_W = clog2(RATIO+1) (4)
// PORTS
//  clk        in   1          single clock
//  rst_n      in   1          asynchronous reset, active low
//  in_en      in   1          input word offered
//  in_rdy     out  1          block can accept; transfer = in_en & in_rdy
//  in_data    in   IN_WIDTH   narrow input word
//  flush      in   1          close partial word (present only with FIFOIN_FLUSH_EN)
//  out_vld    out  1          wide word available at head of queue
//  out_en     in   1          consumer accepts; pop = out_vld & out_en
//  out_data   out  OUT_WIDTH  wide word, first-accepted lane in [IN_WIDTH-1:0]
//  out_lanes  out  LANE_W     valid lanes in out_data (1..RATIO)
// BEHAVIOUR
//  - Reset (async assert, sync release on clk): lane cnt=0, acc=0, queue empty;
//    in_rdy=1, out_vld=0, out_data=0, out_lanes=0, flush_pend=0.
//  - Lane k (k=cnt) of accepted word written to acc[k*IN_WIDTH +: IN_WIDTH]; cnt++.
//  - On accept with cnt==RATIO-1: {in_data, acc[lower lanes]} pushed to queue, cnt->0, acc cleared.
//  - Latency: RATIO-th word accepted cycle N -> out_vld=1 with that data cycle N+1.
//  - Queue: 2 entries, FIFO order; push and pop in same cycle both take effect (count unchanged).
//  - in_rdy = !(q_cnt==2 & cnt==RATIO-1) & !flush_pend; registered from state only, never
//    combinationally dependent on out_en (no ready/valid loop).
//  - Queue full, cnt<RATIO-1: narrow words still accepted into acc (in_rdy=1).
//  - out_data/out_lanes hold stable while out_vld=1 and out_en=0.
//  - out_vld=0: out_data/out_lanes hold last popped value (0 after reset); no X on outputs.
//  - cnt wraps RATIO-1 -> 0 only on push; no other wrap.
//  - Reset mid-word: partial acc discarded, queued words discarded, no output pulse.
// CONFIGURATION
//  FIFOIN_FLUSH_EN defined:
//   - flush=1 with cnt>0 (counting a word accepted in the same cycle) closes the word:
//     unfilled lanes zero, out_lanes=lanes filled; cnt->0.
//   - flush with in_en&in_rdy same cycle: word included before close.
//   - flush with cnt==0 and no accept: ignored, no push.
//   - queue full at flush: flush_pend=1, in_rdy=0 until push completes (<=1 cycle after a pop).
//   - flush when word completes naturally same cycle: single full push, out_lanes=RATIO.
//  FIFOIN_FLUSH_EN undefined: no flush port, no flush_pend; out_lanes constant RATIO
//   whenever out_vld=1 (0 after reset until first push).
// TESTING
//  1. Reset, out_en=1, in_en=1 with 8 words 0x0..0x7 back-to-back -> one cycle after word 7:
//     out_vld=1, out_data=0x00000007_..._00000000, out_lanes=8; in_rdy stays 1 throughout.
//  2. out_en=0, stream 24 words -> 2 wide words queued, in_rdy drops exactly when cnt==7
//     with q_cnt==2; set out_en=1 -> pops in order, 24th word accepted, 3rd word out.
//  3. Push and pop same cycle with q_cnt==1 -> q_cnt stays 1, continuous 1 word/8 cycles, no bubble.
//  4. (FLUSH_EN) 3 words 0xA,0xB,0xC then flush -> out_data low 96b = 0xC_B_A, upper 160b=0,
//     out_lanes=3; flush with cnt==0 -> no out_vld.
//  5. (FLUSH_EN) queue full, flush with cnt=5 -> in_rdy=0, flush_pend=1; after one pop the
//     partial word is queued, in_rdy returns 1.
//  6. rst_n low mid-word (cnt=4, q_cnt=1) async -> out_vld=0 immediately; next 8 words form a clean word.

Source files
------------

// File: rtl/fifoin_upsize_if.sv
// fifoin_upsize_if
//   Bundles the narrow input handshake and the wide output handshake of
//   fifoin_upsize. The packer connects through the slave modport; whatever
//   feeds it and drains it uses the master modport.
//
//   Handshake rule for both sides: a transfer happens on a rising clk edge
//   exactly when the offering side's valid (in_en / out_vld) and the taking
//   side's ready (in_rdy / out_en) are both 1 in that cycle. A side that
//   offers holds its data stable until the transfer. in_rdy and out_vld
//   come from registered state only.
//
//   Signals: in_en, in_rdy, in_data[IN_WIDTH], flush (FIFOIN_FLUSH_EN only),
//            out_vld, out_en, out_data[IN_WIDTH*RATIO], out_lanes[clog2(RATIO+1)]
interface fifoin_upsize_if #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 8
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int LANE_W    = $clog2(RATIO + 1);

  logic                 in_en;
  logic                 in_rdy;
  logic [IN_WIDTH-1:0]  in_data;
`ifdef FIFOIN_FLUSH_EN
  logic                 flush;
`endif
  logic                 out_vld;
  logic                 out_en;
  logic [OUT_WIDTH-1:0] out_data;
  logic [LANE_W-1:0]    out_lanes;

`ifdef FIFOIN_FLUSH_EN
  modport master (output in_en, in_data, flush, out_en,
                  input  in_rdy, out_vld, out_data, out_lanes);
  modport slave  (input  in_en, in_data, flush, out_en,
                  output in_rdy, out_vld, out_data, out_lanes);
`else
  modport master (output in_en, in_data, out_en,
                  input  in_rdy, out_vld, out_data, out_lanes);
  modport slave  (input  in_en, in_data, out_en,
                  output in_rdy, out_vld, out_data, out_lanes);
`endif
endinterface

// File: rtl/fifoin_upsize.sv
// fifoin_upsize
//   Single-clock narrow-to-wide packer (default 32 -> 256 bit). Accepted
//   narrow words fill lanes of an accumulator from lane 0 upwards; the
//   RATIO-th word completes the wide word, which is pushed into a 2-entry
//   output queue. The queue head drives out_data/out_lanes directly, so a
//   completed word is visible the cycle after its last narrow word.
//
//   Optional feature macro: FIFOIN_FLUSH_EN adds a flush input that closes a
//   partial word (unfilled lanes zero, out_lanes = lanes filled). Without
//   it, out_lanes is RATIO for every pushed word.
//
//   Ports:
//     clk    - single clock
//     rst_n  - asynchronous reset, active low
//     bus    - fifoin_upsize_if.slave: in_en/in_rdy/in_data[/flush],
//              out_vld/out_en/out_data/out_lanes
module fifoin_upsize #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 8
) (
  input logic            clk,
  input logic            rst_n,
  fifoin_upsize_if.slave bus
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int LANE_W    = $clog2(RATIO + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [LANE_W-1:0] FULL_LANES = LANE_W'(RATIO);

  // Accumulator state
  logic [LANE_W-1:0]    cnt;
  logic [OUT_WIDTH-1:0] acc;

  // Output queue: head is what the consumer sees, tail is the second entry.
  logic [1:0]           q_cnt;
  logic [OUT_WIDTH-1:0] head_data;
  logic [LANE_W-1:0]    head_lanes;
  logic [OUT_WIDTH-1:0] tail_data;
  logic [LANE_W-1:0]    tail_lanes;

  logic                 flush_pend;

  // Next-state signals
  logic                 accept;
  logic                 pop;
  logic                 push;
  logic [OUT_WIDTH-1:0] push_data;
  logic [LANE_W-1:0]    push_lanes;
  logic [OUT_WIDTH-1:0] acc_ins;
  logic [LANE_W-1:0]    cnt_ins;
  logic [OUT_WIDTH-1:0] acc_nxt;
  logic [LANE_W-1:0]    cnt_nxt;
  logic                 flush_pend_nxt;

  // Ready depends on state only: the one case a word cannot be taken is when
  // it would complete a wide word with nowhere to put it.
  assign bus.in_rdy    = !((q_cnt == 2'd2) && (cnt == LAST_LANE)) && !flush_pend;
  assign bus.out_vld   = (q_cnt != 2'd0);
  assign bus.out_data  = head_data;
  assign bus.out_lanes = head_lanes;

  assign accept = bus.in_en & bus.in_rdy;
  assign pop    = bus.out_vld & bus.out_en;

  always_comb begin
    acc_ins = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (accept && (cnt == LANE_W'(k))) begin
        acc_ins[k*IN_WIDTH +: IN_WIDTH] = bus.in_data;
      end
    end
    cnt_ins = cnt + LANE_W'(accept);
  end

  always_comb begin
    push           = 1'b0;
    push_data      = acc_ins;
    push_lanes     = FULL_LANES;
    acc_nxt        = acc_ins;
    cnt_nxt        = cnt_ins;
    flush_pend_nxt = flush_pend;

    if (accept && (cnt == LAST_LANE)) begin
      // Natural completion wins over a same-cycle flush: one full push.
      push    = 1'b1;
      acc_nxt = '0;
      cnt_nxt = '0;
    end
`ifdef FIFOIN_FLUSH_EN
    else if ((bus.flush || flush_pend) && (cnt_ins != '0)) begin
      // Lanes above cnt_ins are already zero because acc is cleared on
      // every push, so the partial word needs no masking.
      if (q_cnt != 2'd2) begin
        push           = 1'b1;
        push_lanes     = cnt_ins;
        acc_nxt        = '0;
        cnt_nxt        = '0;
        flush_pend_nxt = 1'b0;
      end else begin
        flush_pend_nxt = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt_nxt;
      acc <= acc_nxt;
    end
  end

`ifdef FIFOIN_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
    end else begin
      flush_pend <= flush_pend_nxt;
    end
  end
`else
  assign flush_pend = 1'b0;
`endif

  // Queue update. The head register keeps the last popped word when the
  // queue drains, so outputs never go X and hold their final value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt      <= 2'd0;
      head_data  <= '0;
      head_lanes <= '0;
      tail_data  <= '0;
      tail_lanes <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (q_cnt == 2'd0) begin
            head_data  <= push_data;
            head_lanes <= push_lanes;
          end else begin
            tail_data  <= push_data;
            tail_lanes <= push_lanes;
          end
          q_cnt <= q_cnt + 2'd1;
        end
        2'b01: begin
          if (q_cnt == 2'd2) begin
            head_data  <= tail_data;
            head_lanes <= tail_lanes;
          end
          q_cnt <= q_cnt - 2'd1;
        end
        2'b11: begin
          if (q_cnt == 2'd1) begin
            head_data  <= push_data;
            head_lanes <= push_lanes;
          end else begin
            head_data  <= tail_data;
            head_lanes <= tail_lanes;
            tail_data  <= push_data;
            tail_lanes <= push_lanes;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // flush_nxt is unused in the default build; tie it off explicitly.
  logic unused_ok;
  assign unused_ok = flush_pend_nxt;

endmodule
